// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
//   Turns signed speed commands into the signed PWM duty of one LMD18200 driver.
//   The duty is slew-limited, passes through a zero-crossing dead time before any
//   direction reversal, and is forced to zero on fault or e-stop.
//   Optional command watchdog: define MOTOR_SEQ_WDT_EN to build it in.
`ifndef PWM_RES
`define PWM_RES 8
`endif

module motor_cmd_sequencer #(
  parameter int NBITS     = `PWM_RES + 1,
  parameter int STEP      = 4,
  parameter int TICK_DIV  = 1000,
  parameter int DEADTIME  = 8,
  parameter int WDT_TICKS = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [NBITS-1:0] cmd_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    fault_i,
  input  logic                    estop_i,
  input  logic                    clear_i,
  output logic signed [NBITS-1:0] pwm_o,
  output logic                    en_o,
  output logic [2:0]              state_o,
  output logic                    at_target_o,
  output logic                    wdt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_DWELL = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic signed [NBITS-1:0] MAX_POS  = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic signed [NBITS-1:0] MOST_NEG = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic signed [NBITS:0]   STEP_W   = (NBITS+1)'(STEP);

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q;
  logic                    tick;
  logic signed [NBITS-1:0] pwm_q, pwm_d, target_q, target_d;
  logic signed [NBITS-1:0] cmd_clamped, pwm_step;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic                    dir_q, dir_d;     // sign of the duty before the reversal began
  logic                    accept, fault_any, opposite;
  logic signed [NBITS:0]   pwm_ext, goal_ext, diff, mag;
  logic [NBITS-1:0]        step_sz;

  assign fault_any   = fault_i | estop_i;
  assign cmd_ready_o = (state_q != S_FAULT) & ~fault_any;
  assign accept      = cmd_valid_i & cmd_ready_o;
  // Symmetric range: the most negative code would have no positive mirror.
  assign cmd_clamped = (cmd_i == MOST_NEG) ? -MAX_POS : cmd_i;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Free-running ramp-tick prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  // One slew step. While the target opposes the current duty the goal is zero,
  // so a reversal always stops at zero first. The extra bit keeps target-pwm
  // from wrapping; the step arithmetic itself is modulo 2^NBITS and lands exactly.
  assign opposite = (pwm_q != '0) && (target_q != '0) &&
                    (pwm_q[NBITS-1] != target_q[NBITS-1]);
  assign pwm_ext  = {pwm_q[NBITS-1], pwm_q};
  assign goal_ext = opposite ? '0 : {target_q[NBITS-1], target_q};
  assign diff     = goal_ext - pwm_ext;
  assign mag      = diff[NBITS] ? -diff : diff;
  assign step_sz  = (mag > STEP_W) ? STEP_W[NBITS-1:0] : mag[NBITS-1:0];
  assign pwm_step = diff[NBITS] ? (pwm_q - step_sz) : (pwm_q + step_sz);

`ifdef MOTOR_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  logic [WW-1:0] wdt_q, wdt_d;
  logic          wflag_q, wflag_d;
`endif

  // Next-state, target, duty and watchdog decisions.
  always_comb begin
    state_d  = state_q;
    pwm_d    = pwm_q;
    target_d = target_q;
    dwell_d  = dwell_q;
    dir_d    = dir_q;
`ifdef MOTOR_SEQ_WDT_EN
    wdt_d    = wdt_q;
    wflag_d  = wflag_q;
`endif
    if (accept) target_d = cmd_clamped;
`ifdef MOTOR_SEQ_WDT_EN
    if (state_q == S_FAULT) begin
      wdt_d = '0;
    end else if (accept) begin
      wdt_d   = '0;
      wflag_d = 1'b0;
    end else if (tick && (wdt_q != WW'(WDT_TICKS))) begin
      wdt_d = wdt_q + WW'(1);
      // Expiry only drops the target; the normal ramp brings the motor down.
      if (wdt_d == WW'(WDT_TICKS)) begin
        target_d = '0;
        wflag_d  = 1'b1;
      end
    end
`endif
    case (state_q)
      S_IDLE: begin
        pwm_d = '0;
        if (target_q != '0) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (tick) begin
          pwm_d = pwm_step;
          if ((pwm_step == '0) && opposite) begin
            state_d = S_DWELL;
            dwell_d = '0;
            dir_d   = pwm_q[NBITS-1];
          end else if (pwm_step == target_q) begin
            state_d = (target_q == '0) ? S_IDLE : S_HOLD;
          end
        end
      end
      S_DWELL: begin
        pwm_d = '0;
        if (target_q == '0) begin
          state_d = S_IDLE;
        end else if (target_q[NBITS-1] == dir_q) begin
          state_d = S_RAMP;
        end else if (tick) begin
          // DEADTIME ticks are skipped at zero; the following tick takes the first step.
          if (dwell_q == DW'(DEADTIME)) begin
            pwm_d   = pwm_step;
            state_d = (pwm_step == target_q) ? S_HOLD : S_RAMP;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
      S_HOLD: begin
        if (target_q != pwm_q) state_d = S_RAMP;
      end
      S_FAULT: begin
        pwm_d    = '0;
        target_d = '0;
        if (clear_i && !fault_any) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pwm_d   = '0;
      end
    endcase
    // Fault or e-stop wins over everything, with no ramp.
    if (fault_any) begin
      state_d  = S_FAULT;
      pwm_d    = '0;
      target_d = '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pwm_q    <= '0;
      target_q <= '0;
      dwell_q  <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_q    <= pwm_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      dir_q    <= dir_d;
    end
  end

`ifdef MOTOR_SEQ_WDT_EN
  // Watchdog counter and sticky expiry flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_q   <= '0;
      wflag_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      wflag_q <= wflag_d;
    end
  end
  assign wdt_o = wflag_q;
`else
  // No watchdog: never true for a legal WDT_TICKS, so this is a constant 0.
  assign wdt_o = (WDT_TICKS < 1);
`endif

  assign pwm_o       = pwm_q;
  assign state_o     = state_q;
  assign en_o        = (state_q == S_RAMP) || (state_q == S_DWELL) || (state_q == S_HOLD);
  assign at_target_o = (pwm_q == target_q) && (state_q != S_FAULT);

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer: table of ramp transactions plus
// hand-written reset, clamp, fault/e-stop and watchdog sequences.
module tb_motor_cmd_sequencer;
  localparam int NBITS = 9, STEP = 8, TICK_DIV = 4, DEADTIME = 3, WDT_TICKS = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic signed [NBITS-1:0] cmd_i = '0;
  logic                    cmd_valid_i = 1'b0;
  logic                    cmd_ready_o;
  logic                    fault_i = 1'b0, estop_i = 1'b0, clear_i = 1'b0;
  logic signed [NBITS-1:0] pwm_o;
  logic                    en_o;
  logic [2:0]              state_o;
  logic                    at_target_o, wdt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  motor_cmd_sequencer #(
    .NBITS(NBITS), .STEP(STEP), .TICK_DIV(TICK_DIV), .DEADTIME(DEADTIME), .WDT_TICKS(WDT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .fault_i(fault_i), .estop_i(estop_i), .clear_i(clear_i), .pwm_o(pwm_o), .en_o(en_o),
    .state_o(state_o), .at_target_o(at_target_o), .wdt_o(wdt_o)
  );

  typedef struct packed {
    logic signed [15:0] cmd;
    logic [3:0]         n;       // number of duty changes expected
    logic [3:0]         long_k;  // index of the change that follows the dead time (0 = none)
    logic [5:0][15:0]   seq;     // expected duty after each change
    logic [2:0]         fin;     // expected final state
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input int cmd, input int n, input int lk,
                              input int s0, input int s1, input int s2,
                              input int s3, input int s4, input int s5, input int fin);
    vec_t v;
    v.cmd = 16'(cmd); v.n = 4'(n); v.long_k = 4'(lk);
    v.seq[0] = 16'(s0); v.seq[1] = 16'(s1); v.seq[2] = 16'(s2);
    v.seq[3] = 16'(s3); v.seq[4] = 16'(s4); v.seq[5] = 16'(s5);
    v.fin = 3'(fin);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int c);
    cmd_i = NBITS'(c);
    cmd_valid_i = 1'b1;
    cyc();
    cmd_valid_i = 1'b0;
  endtask

  // Issue one command and follow the duty change by change.
  task automatic run_vec(input int idx, input vec_t v);
    logic signed [NBITS-1:0] prev;
    int k, since, budget, saw_dwell;
    send(int'(v.cmd));
    prev = pwm_o; k = 0; since = 0; budget = 300; saw_dwell = 0;
    while (k < int'(v.n) && budget > 0) begin
      cyc();
      budget--; since++;
      if (state_o == 3'd2 && pwm_o == 0 && en_o) saw_dwell = 1;
      if (pwm_o !== prev) begin
        check($sformatf("vec%0d value%0d", idx, k), int'(pwm_o), int'($signed(v.seq[k])));
        if (k > 0)
          check($sformatf("vec%0d gap%0d", idx, k), since,
                (k == int'(v.long_k)) ? (DEADTIME + 1) * TICK_DIV : TICK_DIV);
        prev = pwm_o; since = 0; k++;
      end
    end
    if (k < int'(v.n)) check($sformatf("vec%0d timeout_changes", idx), k, int'(v.n));
    if (v.long_k != 0) check($sformatf("vec%0d dwell_seen", idx), saw_dwell, 1);
    repeat (2) cyc();
    check($sformatf("vec%0d state", idx), int'(state_o), int'(v.fin));
    check($sformatf("vec%0d pwm_final", idx), int'(pwm_o), int'($signed(v.seq[int'(v.n) - 1])));
    check($sformatf("vec%0d at_target", idx), int'(at_target_o), 1);
    check($sformatf("vec%0d en", idx), int'(en_o), (v.fin == 3'd3) ? 1 : 0);
    $display("vec%0d cmd=%0d changes=%0d pwm=%0d state=%0d", idx, int'(v.cmd), k, int'(pwm_o), state_o);
  endtask

  // Ramp to a (possibly far) target, re-offering the same command periodically.
  task automatic ramp_far(input string name, input int c, input int want_state,
                          input int want_changes, input int want_first);
    logic signed [NBITS-1:0] prev;
    int changes, budget, first;
    send(c);
    prev = pwm_o; changes = 0; budget = 400; first = 0;
    while (int'(state_o) != want_state && budget > 0) begin
      cmd_valid_i = (budget % 32 == 0);
      cyc();
      budget--;
      if (pwm_o !== prev) begin
        if (changes == 0) first = int'(pwm_o);
        changes++; prev = pwm_o;
      end
    end
    cmd_valid_i = 1'b0;
    check({name, "_state"}, int'(state_o), want_state);
    check({name, "_changes"}, changes, want_changes);
    check({name, "_first"}, first, want_first);
    $display("%s cmd=%0d changes=%0d pwm=%0d", name, c, changes, int'(pwm_o));
  endtask

  initial begin
    int budget, c;
    vecs[0] = mk( 40, 5, 0,   8,  16, 24,  32,  40,   0, 3);
    vecs[1] = mk( 20, 3, 0,  32,  24, 20,   0,   0,   0, 3);
    vecs[2] = mk(  0, 3, 0,  12,   4,  0,   0,   0,   0, 0);
    vecs[3] = mk( 13, 2, 0,   8,  13,  0,   0,   0,   0, 3);
    vecs[4] = mk( 16, 1, 0,  16,   0,  0,   0,   0,   0, 3);
    vecs[5] = mk(  0, 2, 0,   8,   0,  0,   0,   0,   0, 0);
    vecs[6] = mk( 20, 3, 0,   8,  16, 20,   0,   0,   0, 3);
    vecs[7] = mk(-20, 6, 3,  12,   4,  0,  -8, -16, -20, 3);
    vecs[8] = mk(  0, 3, 0, -12,  -4,  0,   0,   0,   0, 0);

    // Reset state.
    repeat (2) cyc();
    rst = 1'b1;
    repeat (3) cyc();
    check("reset_pwm", int'(pwm_o), 0);
    check("reset_en", int'(en_o), 0);
    check("reset_state", int'(state_o), 0);
    check("reset_ready", int'(cmd_ready_o), 1);
    check("reset_at_target", int'(at_target_o), 1);
    check("reset_wdt", int'(wdt_o), 0);
    $display("reset: pwm=%0d en=%0d state=%0d", int'(pwm_o), en_o, state_o);

    // Asynchronous reset mid-ramp.
    send(40);
    budget = 40;
    while (pwm_o != 16 && budget > 0) begin cyc(); budget--; end
    check("midramp_reached16", int'(pwm_o), 16);
    rst = 1'b0;
    #2;
    check("async_reset_pwm", int'(pwm_o), 0);
    check("async_reset_en", int'(en_o), 0);
    check("async_reset_state", int'(state_o), 0);
    cyc();
    rst = 1'b1;
    repeat (12) cyc();
    check("after_reset_state", int'(state_o), 0);
    check("after_reset_pwm", int'(pwm_o), 0);
    $display("midramp reset: pwm=%0d state=%0d", int'(pwm_o), state_o);

    // Table of ramp transactions, each starting where the previous one ended.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Clamp of the most negative command, then ramp back down to zero.
    ramp_far("clamp_neg", -256, 3, 32, -8);
    check("clamp_neg_pwm", int'(pwm_o), -255);
    check("clamp_neg_at_target", int'(at_target_o), 1);
    ramp_far("back_to_zero", 0, 0, 32, -247);
    check("back_to_zero_pwm", int'(pwm_o), 0);

    // Fault at +40, with a command offered in the same cycle.
    run_vec(0, vecs[0]);
    fault_i = 1'b1; cmd_i = NBITS'(-100); cmd_valid_i = 1'b1;
    #1;
    check("fault_ready_low", int'(cmd_ready_o), 0);
    cyc();
    cmd_valid_i = 1'b0;
    check("fault_pwm", int'(pwm_o), 0);
    check("fault_en", int'(en_o), 0);
    check("fault_state", int'(state_o), 4);
    check("fault_at_target", int'(at_target_o), 0);
    clear_i = 1'b1; cyc(); clear_i = 1'b0; cyc();
    check("fault_clear_ignored", int'(state_o), 4);
    fault_i = 1'b0; cyc();
    check("fault_waits_clear", int'(state_o), 4);
    check("fault_ready_in_fault", int'(cmd_ready_o), 0);
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    check("fault_exit_idle", int'(state_o), 0);
    repeat (8) cyc();
    check("fault_cmd_dropped_state", int'(state_o), 0);
    check("fault_cmd_dropped_pwm", int'(pwm_o), 0);
    $display("fault: state=%0d pwm=%0d", state_o, int'(pwm_o));

    // E-stop from HOLD at +13.
    run_vec(3, vecs[3]);
    estop_i = 1'b1; cyc();
    check("estop_state", int'(state_o), 4);
    check("estop_pwm", int'(pwm_o), 0);
    estop_i = 1'b0; clear_i = 1'b1; cyc(); clear_i = 1'b0;
    check("estop_exit_idle", int'(state_o), 0);
    $display("estop: state=%0d pwm=%0d", state_o, int'(pwm_o));

`ifdef MOTOR_SEQ_WDT_EN
    // Watchdog expiry with no further commands.
    send(40);
    c = 0;
    while (!wdt_o && c < 100) begin cyc(); c++; end
    check("wdt_latency_ok", int'(c >= 61 && c <= 64), 1);
    check("wdt_pwm_at_expiry", int'(pwm_o), 40);
    budget = 100;
    while (state_o != 3'd0 && budget > 0) begin
      cyc(); budget--;
      if (state_o == 3'd4) check("wdt_no_fault", int'(state_o), 0);
    end
    check("wdt_idle", int'(state_o), 0);
    check("wdt_pwm_zero", int'(pwm_o), 0);
    check("wdt_flag_sticky", int'(wdt_o), 1);
    send(13);
    check("wdt_cleared", int'(wdt_o), 0);
    $display("watchdog: latency=%0d state=%0d", c, state_o);
`else
    // No watchdog: +40 held for 100 ticks.
    run_vec(0, vecs[0]);
    repeat (100 * TICK_DIV) cyc();
    check("hold_pwm", int'(pwm_o), 40);
    check("hold_state", int'(state_o), 3);
    check("hold_en", int'(en_o), 1);
    check("hold_wdt", int'(wdt_o), 0);
    c = 100;
    $display("long hold: ticks=%0d pwm=%0d", c, int'(pwm_o));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
